// File: rtl/mrh_pkg.sv
// mrh_pkg: shared L2 request/response types and the tag width used across the memory hierarchy
package mrh_pkg;
  localparam int L2_TAG_W = 8;
  typedef struct packed {
    logic [L2_TAG_W-1:0] tag;
    logic [31:0]         addr;
  } l2_req_t;
  typedef struct packed {
    logic [L2_TAG_W-1:0] tag;
    logic [31:0]         data;
  } l2_resp_t;
endpackage

// File: rtl/mrh_l2_req_arbiter_if.sv
// mrh_l2_req_arbiter_if: requester, downstream L2 and routed-response channels of the L2 request arbiter
interface mrh_l2_req_arbiter_if
  import mrh_pkg::*;
#(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]          i_req_valid;
  l2_req_t  [N_REQ-1:0]      i_req_payload;
  logic [N_REQ-1:0]          o_req_ready;
  logic                      o_l2_req_valid;
  logic                      i_l2_req_ready;
  l2_req_t                   o_l2_req_payload;
  logic                      i_l2_resp_valid;
  l2_resp_t                  i_l2_resp_payload;
  logic                      o_l2_resp_ready;
  logic [N_REQ-1:0]          o_resp_valid;
  l2_resp_t [N_REQ-1:0]      o_resp_payload;
  logic [N_REQ-1:0]          i_resp_ready;
  modport master (
    input  i_req_valid, i_req_payload, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_payload, i_resp_ready,
    output o_req_ready, o_l2_req_valid, o_l2_req_payload, o_l2_resp_ready, o_resp_valid, o_resp_payload
  );
  modport slave (
    output i_req_valid, i_req_payload, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_payload, i_resp_ready,
    input  o_req_ready, o_l2_req_valid, o_l2_req_payload, o_l2_resp_ready, o_resp_valid, o_resp_payload
  );
endinterface

// File: rtl/mrh_rr_arbiter.sv
// mrh_rr_arbiter: N-wide one-hot round-robin grant; pointer moves one past the winner when i_adv is high
module mrh_rr_arbiter #(
  parameter int N = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [N-1:0]                  i_req,
  input  logic                          i_adv,
  output logic [N-1:0]                  o_gnt,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] o_idx
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  if (N == 1) begin : g_one
    assign o_gnt = i_req;
    assign o_idx = '0;
  end else begin : g_rr
    logic [W-1:0] ptr_q, ptr_d, j;
    // Scan from the pointer upward with wrap; the nearest requester wins
    always_comb begin
      o_idx = '0;
      j = '0;
      for (int o = N - 1; o >= 0; o--) begin
        j = W'((int'(ptr_q) + o) % N);
        if (i_req[j]) o_idx = j;
      end
    end
    assign o_gnt = (|i_req) ? N'(1) << o_idx : '0;
    assign ptr_d = (int'(o_idx) == N - 1) ? '0 : o_idx + W'(1);
    // Pointer register, reset to channel 0
    always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) ptr_q <= '0;
      else if (i_adv) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mrh_l2_req_arbiter.sv
// mrh_l2_req_arbiter: round-robin merge of N_REQ requesters onto one L2 port with tag-based response routing.
// Optional per-channel outstanding limit enabled by `define MRH_L2_ARB_OUTSTANDING_LIMIT_EN.
module mrh_l2_req_arbiter
  import mrh_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mrh_l2_req_arbiter_if.master bus
);
  localparam int IDX_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0] elig, gnt, lim, resp_sel;
  logic [IDX_W-1:0] idx, k;
  logic             vld_q, vld_d, free, k_ok;
  l2_req_t          pay_q, pay_d;
  assign free  = ~vld_q | bus.i_l2_req_ready;
  assign elig  = i_reset ? '0 : bus.i_req_valid & ~lim & {N_REQ{free}};
  assign vld_d = free ? |gnt : vld_q;
  mrh_rr_arbiter #(.N(N_REQ)) u_rr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (elig),
    .i_adv   (|gnt),
    .o_gnt   (gnt),
    .o_idx   (idx)
  );
  assign bus.o_req_ready      = gnt;
  assign bus.o_l2_req_valid   = vld_q;
  assign bus.o_l2_req_payload = pay_q;
  // Stamp the granted channel into the top tag bits so its response can be routed back
  always_comb begin
    pay_d = bus.i_req_payload[idx];
    if (N_REQ > 1) pay_d.tag[L2_TAG_W-1 -: IDX_W] = idx;
  end
  // Output slot valid: refilled whenever it is free, otherwise held until L2 accepts
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) vld_q <= 1'b0;
    else vld_q <= vld_d;
  // Payload loads only on a grant, so it stays stable while L2 stalls
  always_ff @(posedge i_clk)
    if (|gnt) pay_q <= pay_d;
  assign k    = N_REQ > 1 ? bus.i_l2_resp_payload.tag[L2_TAG_W-1 -: IDX_W] : '0;
  assign k_ok = int'(k) < N_REQ;
  assign resp_sel = (i_reset | ~k_ok) ? '0 : N_REQ'(1) << k;
  assign bus.o_resp_valid    = resp_sel & {N_REQ{bus.i_l2_resp_valid}};
  assign bus.o_resp_payload  = {N_REQ{bus.i_l2_resp_payload}};
  assign bus.o_l2_resp_ready = ~i_reset & (~k_ok | bus.i_resp_ready[k]);
`ifdef MRH_L2_ARB_OUTSTANDING_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [N_REQ-1:0] resp_fire;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  assign resp_fire = bus.o_resp_valid & bus.i_resp_ready;
  // Grants count up, routed responses count down; an idle channel never goes below zero
  always_comb begin
    cnt_d = cnt_q;
    lim   = '0;
    for (int n = 0; n < N_REQ; n++) begin
      cnt_d[n] = cnt_q[n] + CNT_W'(gnt[n]) - CNT_W'(resp_fire[n] && cnt_q[n] != '0);
      lim[n]   = int'(cnt_q[n]) == MAX_OUTSTANDING;
    end
  end
  // Outstanding counters, cleared by reset
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) for (int n = 0; n < N_REQ; n++) cnt_q[n] <= '0;
    else cnt_q <= cnt_d;
`else
  assign lim = '0;
`endif
endmodule

// File: tb/tb_mrh_l2_req_arbiter.sv
// tb_mrh_l2_req_arbiter: directed stimulus with a cycle model of the arbiter and literal spot checks
module tb_mrh_l2_req_arbiter;
  import mrh_pkg::*;
  localparam int N = 2;
  localparam int MAXO = 2;
`ifdef MRH_L2_ARB_OUTSTANDING_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mrh_l2_req_arbiter_if #(.N_REQ(N)) bus ();
  mrh_l2_req_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  int checks = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  int ptr;
  bit ov;
  l2_req_t opay;
  int cnt [N];
  function automatic int pick();
    for (int o = 0; o < N; o++) begin
      int n;
      n = (ptr + o) % N;
      if (bus.i_req_valid[n] && (!LIM || cnt[n] < MAXO)) return n;
    end
    return -1;
  endfunction
  function automatic bit slot_free();
    return !ov || bus.i_l2_req_ready;
  endfunction
  function automatic int resp_ch();
    return int'(bus.i_l2_resp_payload.tag) >> (L2_TAG_W - 1);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr = 0;
      ov = 1'b0;
      cnt = '{default: 0};
    end else begin
      int g, k;
      bit f;
      f = slot_free();
      g = f ? pick() : -1;
      k = resp_ch();
      if (LIM && bus.i_l2_resp_valid && bus.i_resp_ready[k] && cnt[k] > 0) cnt[k]--;
      if (g >= 0) begin
        if (LIM) cnt[g]++;
        opay = bus.i_req_payload[g];
        opay.tag = (opay.tag & 8'h7f) | 8'(g << 7);
        ptr = (g + 1) % N;
      end
      if (f) ov = (g >= 0);
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", bus.o_req_ready, 0);
      chk("rst_l2_req_valid", bus.o_l2_req_valid, 0);
      chk("rst_resp_valid", bus.o_resp_valid, 0);
      chk("rst_l2_resp_ready", bus.o_l2_resp_ready, 0);
    end else begin
      int g, k;
      g = slot_free() ? pick() : -1;
      k = resp_ch();
      chk("model_req_ready", bus.o_req_ready, g >= 0 ? 64'(1) << g : 0);
      chk("model_l2_req_valid", bus.o_l2_req_valid, ov);
      if (ov) chk("model_l2_req_payload", bus.o_l2_req_payload, opay);
      chk("model_resp_valid", bus.o_resp_valid, bus.i_l2_resp_valid ? 64'(1) << k : 0);
      chk("model_l2_resp_ready", bus.o_l2_resp_ready, bus.i_resp_ready[k]);
      if (bus.i_l2_resp_valid) chk("model_resp_payload", bus.o_resp_payload[k], bus.i_l2_resp_payload);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic setreq(input int n, input logic [7:0] tag);
    bus.i_req_payload[n] = '{tag: tag, addr: 32'h1000 + 32'(tag)};
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_l2_req_ready = 1'b0;
    bus.i_l2_resp_valid = 1'b0;
    bus.i_resp_ready = '0;
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    bus.i_req_valid = '0;
    bus.i_req_payload = '0;
    bus.i_l2_req_ready = 1'b0;
    bus.i_l2_resp_valid = 1'b0;
    bus.i_l2_resp_payload = '0;
    bus.i_resp_ready = '0;
    do_reset();
    setreq(0, 8'h11);
    setreq(1, 8'h05);
    bus.i_req_valid = 2'b11;
    bus.i_l2_req_ready = 1'b1;
    @(negedge clk);
    chk("rr_c0_ready", bus.o_req_ready, 2'b01);
    chk("rr_c0_l2_valid", bus.o_l2_req_valid, 0);
    step();
    @(negedge clk);
    chk("rr_c1_ready", bus.o_req_ready, 2'b10);
    chk("rr_c1_tag", bus.o_l2_req_payload.tag, 8'h11);
    step();
    @(negedge clk);
    chk("rr_c2_ready", bus.o_req_ready, 2'b01);
    chk("tag_ch1_0x85", bus.o_l2_req_payload.tag, 8'h85);
    step();
    @(negedge clk);
    chk("rr_c3_ready", bus.o_req_ready, 2'b10);
    chk("rr_c3_l2_valid", bus.o_l2_req_valid, 1);
    step();
    bus.i_req_valid = '0;
    bus.i_l2_resp_valid = 1'b1;
    bus.i_l2_resp_payload = '{tag: 8'h85, data: 32'hcafe0001};
    bus.i_resp_ready = 2'b11;
    @(negedge clk);
    chk("route_0x85_valid", bus.o_resp_valid, 2'b10);
    chk("route_0x85_ready", bus.o_l2_resp_ready, 1);
    step();
    bus.i_l2_resp_valid = 1'b0;
    do_reset();
    setreq(0, 8'h22);
    bus.i_req_valid = 2'b01;
    @(negedge clk);
    chk("stall_first_grant", bus.o_req_ready, 2'b01);
    step();
    setreq(0, 8'h33);
    setreq(1, 8'h44);
    bus.i_req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_ready", bus.o_req_ready, 0);
      chk("stall_tag_stable", bus.o_l2_req_payload.tag, 8'h22);
      step();
    end
    bus.i_l2_req_ready = 1'b1;
    @(negedge clk);
    chk("release_grant_ch1", bus.o_req_ready, 2'b10);
    chk("release_tag", bus.o_l2_req_payload.tag, 8'h22);
    step();
    bus.i_req_valid = '0;
    @(negedge clk);
    chk("release_next_tag", bus.o_l2_req_payload.tag, 8'hc4);
    step();
    do_reset();
    setreq(0, 8'h01);
    bus.i_req_valid = 2'b01;
    bus.i_l2_req_ready = 1'b1;
    @(negedge clk);
    chk("lim_c0", bus.o_req_ready, 2'b01);
    step();
    @(negedge clk);
    chk("lim_c1", bus.o_req_ready, 2'b01);
    step();
    @(negedge clk);
`ifdef MRH_L2_ARB_OUTSTANDING_LIMIT_EN
    chk("lim_third_stalls", bus.o_req_ready, 2'b00);
`else
    chk("nolim_third_granted", bus.o_req_ready, 2'b01);
`endif
    step();
    bus.i_l2_resp_valid = 1'b1;
    bus.i_l2_resp_payload = '{tag: 8'h00, data: 32'h5};
    bus.i_resp_ready = 2'b01;
    @(negedge clk);
    chk("lim_resp_route", bus.o_resp_valid, 2'b01);
`ifdef MRH_L2_ARB_OUTSTANDING_LIMIT_EN
    chk("lim_still_full", bus.o_req_ready, 2'b00);
`endif
    step();
    bus.i_l2_resp_valid = 1'b0;
    @(negedge clk);
    chk("lim_after_resp", bus.o_req_ready, 2'b01);
    step();
    do_reset();
    bus.i_l2_resp_valid = 1'b1;
    bus.i_l2_resp_payload = '{tag: 8'h80, data: 32'h77};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("resp_bp_ready", bus.o_l2_resp_ready, 0);
      chk("resp_bp_valid", bus.o_resp_valid, 2'b10);
      step();
    end
    bus.i_resp_ready = 2'b10;
    @(negedge clk);
    chk("resp_handshake", bus.o_l2_resp_ready, 1);
    step();
    bus.i_l2_resp_valid = 1'b0;
    do_reset();
    setreq(0, 8'h12);
    setreq(1, 8'h34);
    bus.i_req_valid = 2'b01;
    step();
    bus.i_req_valid = '0;
    @(negedge clk);
    chk("mid_valid_before_rst", bus.o_l2_req_valid, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_l2_valid", bus.o_l2_req_valid, 0);
    chk("async_rst_req_ready", bus.o_req_ready, 0);
    step();
    rst = 1'b0;
    bus.i_req_valid = 2'b11;
    bus.i_l2_req_ready = 1'b1;
    @(negedge clk);
    chk("ptr_zero_after_rst", bus.o_req_ready, 2'b01);
    step();
    bus.i_req_valid = '0;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
